// File: rtl/for_output_writeback.sv
// Drains the occupied result sets of the convolution output stage as fixed-size beats
// over a valid/ready channel, then pulses a clear back to the output stage.
module for_output_writeback #(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_OF_SET = 128,
    parameter int NUM_SETS    = 8,
    parameter int BEAT_ELEMS  = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_SETS*DATA_OF_SET*DATA_WIDTH-1:0] res,
    input  logic [NUM_SETS-1:0]                        res_valid,
    input  logic                                       full_flag,
    input  logic                                       start,
    input  logic [ADDR_WIDTH-1:0]                      base_addr,
    output logic                                       wb_valid,
    input  logic                                       wb_ready,
    output logic [ADDR_WIDTH-1:0]                      wb_addr,
    output logic [BEAT_ELEMS*DATA_WIDTH-1:0]           wb_data,
    output logic                                       wb_last,
    output logic                                       clr_o,
    output logic                                       busy,
    output logic                                       done
);

    localparam int BEATS  = DATA_OF_SET / BEAT_ELEMS;
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int SET_W  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RES_W  = NUM_SETS * DATA_OF_SET * DATA_WIDTH;
    localparam int IDX_W  = $clog2(RES_W);
    localparam int LANE_W = BEAT_ELEMS * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, SEEK, DRAIN, CLEAR, WAIT} state_t;

    state_t              state_reg, state_next;
    logic [NUM_SETS-1:0] snap_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [SET_W-1:0]    set_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LANE_W-1:0]   data_reg;

    logic                seek_found;
    logic [SET_W-1:0]    seek_idx;
    logic                others_pending;
    logic                end_of_set;
    logic                trigger;
    logic [SET_W-1:0]    ld_set;
    logic [BEAT_W-1:0]   ld_beat;
    logic [31:0]         elem_off;
    logic [IDX_W-1:0]    bit_off;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [LANE_W-1:0]   ld_data;

    assign trigger    = start | full_flag;
    assign end_of_set = (beat_reg == BEAT_W'(BEATS - 1));

    // Drained sets are cleared from snap, so the lowest remaining bit is the next set.
    always_comb begin
        seek_found = 1'b0;
        seek_idx   = '0;
        for (int i = NUM_SETS - 1; i >= 0; i--) begin
            if (snap_reg[i]) begin
                seek_found = 1'b1;
                seek_idx   = SET_W'(i);
            end
        end
    end

    assign others_pending = |(snap_reg & ~(NUM_SETS'(1) << set_reg));

    // Address/data of the beat to be loaded into the output registers.
    always_comb begin
        if (state_reg == SEEK) begin
            ld_set  = seek_idx;
            ld_beat = '0;
        end else begin
            ld_set  = set_reg;
            ld_beat = beat_reg + BEAT_W'(1);
        end
        elem_off = 32'(ld_set) * 32'(DATA_OF_SET) + 32'(ld_beat) * 32'(BEAT_ELEMS);
        bit_off  = IDX_W'(elem_off * 32'(DATA_WIDTH));
        ld_addr  = base_reg + ADDR_WIDTH'(elem_off * 32'(BYTES));
        ld_data  = res[bit_off +: LANE_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger) state_next = SEEK;
            SEEK:    state_next = seek_found ? DRAIN : CLEAR;
            DRAIN:   if (wb_ready && end_of_set) state_next = others_pending ? SEEK : CLEAR;
            CLEAR:   state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wb_valid = (state_reg == DRAIN);
        wb_last  = (state_reg == DRAIN) && end_of_set && !others_pending;
        clr_o    = (state_reg == CLEAR);
        done     = (state_reg == CLEAR);
        busy     = (state_reg != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_reg <= '0;
            base_reg <= '0;
            set_reg  <= '0;
            beat_reg <= '0;
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        base_reg <= base_addr;
                        snap_reg <= res_valid;
                        set_reg  <= '0;
                        beat_reg <= '0;
                    end
                end
                SEEK: begin
                    if (seek_found) begin
                        set_reg  <= seek_idx;
                        beat_reg <= '0;
                        addr_reg <= ld_addr;
                        data_reg <= ld_data;
                    end
                end
                DRAIN: begin
                    if (wb_ready) begin
                        if (end_of_set) begin
                            snap_reg[set_reg] <= 1'b0;
                            set_reg           <= set_reg + SET_W'(1);
                        end else begin
                            beat_reg <= ld_beat;
                            addr_reg <= ld_addr;
                            data_reg <= ld_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_addr = addr_reg;
    assign wb_data = data_reg;

endmodule

// File: tb/tb_for_output_writeback.sv
// Directed bench for for_output_writeback: expected beats are queued at trigger time
// and popped by a negedge monitor on every handshake.
module tb_for_output_writeback;

    localparam int DW = 32;
    localparam int DS = 128;
    localparam int NS = 8;
    localparam int BE = 4;
    localparam int AW = 32;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [BE*DW-1:0] data;
        logic             last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NS*DS*DW-1:0]  res;
    logic [NS-1:0]        res_valid;
    logic                 full_flag;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [AW-1:0]        wb_addr;
    logic [BE*DW-1:0]     wb_data;
    logic                 wb_last;
    logic                 clr_o;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int fails  = 0;
    int hs_count = 0;
    int clr_count = 0;
    logic [AW-1:0] last_addr = '0;
    beat_t exp_q[$];
    beat_t mon_e;
    bit hs_prev_last = 1'b0;
    bit stall_prev = 1'b0;
    logic [AW-1:0] stall_addr;
    logic [BE*DW-1:0] stall_data;

    always #5 clk = ~clk;

    for_output_writeback #(
        .DATA_WIDTH(DW), .DATA_OF_SET(DS), .NUM_SETS(NS), .BEAT_ELEMS(BE), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .res(res), .res_valid(res_valid), .full_flag(full_flag),
        .start(start), .base_addr(base_addr), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_last(wb_last), .clr_o(clr_o),
        .busy(busy), .done(done)
    );

    function automatic logic [DW-1:0] elem_val(input int s, input int e);
        return 32'hC000_0000 + 32'(s) * 32'h0001_0000 + 32'(e);
    endfunction

    task automatic chk(input string tag, input logic [BE*DW-1:0] got, input logic [BE*DW-1:0] expv);
        checks++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s got %h exp %h", tag, got, expv);
        end
    endtask

    task automatic push_drain(input logic [AW-1:0] base, input logic [NS-1:0] snap);
        int top;
        beat_t t;
        top = -1;
        for (int s = 0; s < NS; s++) if (snap[s]) top = s;
        for (int s = 0; s < NS; s++) begin
            if (snap[s]) begin
                for (int b = 0; b < DS / BE; b++) begin
                    t.addr = base + 32'((s * DS + b * BE) * (DW / 8));
                    for (int j = 0; j < BE; j++) t.data[j*DW +: DW] = elem_val(s, b * BE + j);
                    t.last = (s == top) && (b == DS / BE - 1);
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    task automatic trigger(input logic s, input logic f);
        @(posedge clk); #1;
        start = s;
        full_flag = f;
        @(posedge clk); #1;
        start = 1'b0;
        full_flag = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {127'd0, busy}, '0);
    endtask

    // Handshake monitor: scoreboard pop, stall stability, clear-after-last timing.
    always @(negedge clk) begin
        if (rst) begin
            hs_prev_last = 1'b0;
            stall_prev   = 1'b0;
        end else begin
            if (hs_prev_last) begin
                checks++;
                assert (clr_o === 1'b1 && done === 1'b1) else begin
                    fails++;
                    $error("FAIL clr_after_last got clr_o=%b done=%b exp 1/1", clr_o, done);
                end
            end
            if (stall_prev) begin
                checks++;
                assert (wb_addr === stall_addr && wb_data === stall_data) else begin
                    fails++;
                    $error("FAIL stall_hold got %h/%h exp %h/%h", wb_addr, wb_data, stall_addr, stall_data);
                end
            end
            if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_beat got addr %h exp no beat", wb_addr);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    assert (wb_addr === mon_e.addr && wb_data === mon_e.data && wb_last === mon_e.last) else begin
                        fails++;
                        $error("FAIL beat got %h/%h/%b exp %h/%h/%b", wb_addr, wb_data, wb_last,
                               mon_e.addr, mon_e.data, mon_e.last);
                    end
                end
                hs_count++;
                last_addr = wb_addr;
            end
            if (clr_o === 1'b1) clr_count++;
            hs_prev_last = (wb_valid === 1'b1) && (wb_ready === 1'b1) && (wb_last === 1'b1);
            stall_prev   = (wb_valid === 1'b1) && (wb_ready === 1'b0);
            stall_addr   = wb_addr;
            stall_data   = wb_data;
        end
    end

    initial begin
        int hs0;
        int clr0;
        int n;
        rst = 1'b1; start = 1'b0; full_flag = 1'b0; wb_ready = 1'b1;
        base_addr = '0; res_valid = '0;
        for (int s = 0; s < NS; s++)
            for (int e = 0; e < DS; e++) res[(s * DS + e) * DW +: DW] = elem_val(s, e);

        @(negedge clk);
        chk("reset_valid", {127'd0, wb_valid}, '0);
        chk("reset_busy", {127'd0, busy}, '0);
        chk("reset_clr", {127'd0, clr_o}, '0);
        chk("reset_done", {127'd0, done}, '0);
        chk("reset_last", {127'd0, wb_last}, '0);
        chk("reset_addr", {96'd0, wb_addr}, '0);
        chk("reset_data", wb_data, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Auto full drain via full_flag
        base_addr = 32'h1000; res_valid = 8'hFF;
        push_drain(base_addr, res_valid);
        hs0 = hs_count; clr0 = clr_count;
        trigger(1'b0, 1'b1);
        @(negedge clk);
        chk("full_seek_valid", {127'd0, wb_valid}, '0);
        chk("full_seek_busy", {127'd0, busy}, 128'd1);
        @(negedge clk);
        chk("full_first_valid", {127'd0, wb_valid}, 128'd1);
        chk("full_first_addr", {96'd0, wb_addr}, 128'h1000);
        wait_idle("full_idle", 2000);
        chk("full_queue_empty", 128'(exp_q.size()), '0);
        chk("full_beats", 128'(hs_count - hs0), 128'd256);
        chk("full_last_addr", {96'd0, last_addr}, 128'h1FF0);
        chk("full_clr_count", 128'(clr_count - clr0), 128'd1);

        // Sparse drain: sets 0 and 5
        res_valid = 8'b0010_0001;
        push_drain(base_addr, res_valid);
        hs0 = hs_count; clr0 = clr_count;
        trigger(1'b1, 1'b0);
        wait_idle("sparse_idle", 500);
        chk("sparse_queue_empty", 128'(exp_q.size()), '0);
        chk("sparse_beats", 128'(hs_count - hs0), 128'd64);
        chk("sparse_last_addr", {96'd0, last_addr}, 128'h1BF0);
        chk("sparse_clr_count", 128'(clr_count - clr0), 128'd1);

        // Backpressure: ready pattern 1,0,0,1
        res_valid = 8'h01;
        push_drain(base_addr, res_valid);
        hs0 = hs_count;
        trigger(1'b1, 1'b0);
        for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
            @(posedge clk); #1;
            wb_ready = ((i % 4) == 0) || ((i % 4) == 3);
        end
        wb_ready = 1'b1;
        chk("bp_idle", {127'd0, busy}, '0);
        chk("bp_queue_empty", 128'(exp_q.size()), '0);
        chk("bp_beats", 128'(hs_count - hs0), 128'd32);

        // Empty drain
        res_valid = 8'h00;
        hs0 = hs_count;
        trigger(1'b1, 1'b0);
        @(negedge clk);
        chk("empty_seek_busy", {127'd0, busy}, 128'd1);
        chk("empty_seek_valid", {127'd0, wb_valid}, '0);
        @(negedge clk);
        chk("empty_clr", {127'd0, clr_o}, 128'd1);
        chk("empty_done", {127'd0, done}, 128'd1);
        chk("empty_clr_valid", {127'd0, wb_valid}, '0);
        @(negedge clk);
        chk("empty_wait_busy", {127'd0, busy}, 128'd1);
        chk("empty_wait_clr", {127'd0, clr_o}, '0);
        @(negedge clk);
        chk("empty_idle", {127'd0, busy}, '0);
        chk("empty_beats", 128'(hs_count - hs0), '0);

        // Collision: start while draining, full_flag in WAIT
        res_valid = 8'h01;
        push_drain(base_addr, res_valid);
        hs0 = hs_count; clr0 = clr_count;
        trigger(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("coll_done_seen", {127'd0, done}, 128'd1);
        @(posedge clk); #1 full_flag = 1'b1;
        @(posedge clk); #1 full_flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("coll_stay_idle", {127'd0, busy}, '0);
        end
        chk("coll_beats", 128'(hs_count - hs0), 128'd32);
        chk("coll_clr_count", 128'(clr_count - clr0), 128'd1);
        push_drain(base_addr, res_valid);
        hs0 = hs_count;
        trigger(1'b1, 1'b0);
        wait_idle("coll_new_idle", 500);
        chk("coll_new_beats", 128'(hs_count - hs0), 128'd32);
        chk("coll_queue_empty", 128'(exp_q.size()), '0);

        // Address wrap
        base_addr = 32'hFFFF_FFF0;
        push_drain(base_addr, res_valid);
        trigger(1'b1, 1'b0);
        wait_idle("wrap_idle", 500);
        chk("wrap_queue_empty", 128'(exp_q.size()), '0);
        chk("wrap_last_addr", {96'd0, last_addr}, 128'h1E0);

        // Async reset at beat 10
        base_addr = 32'h2000;
        push_drain(base_addr, res_valid);
        hs0 = hs_count; clr0 = clr_count;
        trigger(1'b1, 1'b0);
        n = 0;
        while ((hs_count - hs0) < 10 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reached_beat10", 128'(hs_count - hs0), 128'd10);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {127'd0, wb_valid}, '0);
        chk("rst_async_busy", {127'd0, busy}, '0);
        chk("rst_async_addr", {96'd0, wb_addr}, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_after_busy", {127'd0, busy}, '0);
        end
        chk("rst_no_clr", 128'(clr_count - clr0), '0);
        chk("rst_beats", 128'(hs_count - hs0), 128'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
